// File: rtl/drr_sched_pkg.sv
// Shared definitions for the deficit round robin scheduler: FSM encoding and
// the default sizing constants used by drr_sched.
package drr_sched_pkg;

  localparam int DRR_DEFAULT_QUANTUM = 1500;
  localparam int DRR_DEFICIT_WIDTH   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    TEST  = 2'd2,
    GRANT = 2'd3
  } drr_state_t;

endpackage

// File: rtl/drr_sched_rr_first_valid.sv
// Rotating-priority search: returns the first set request at or after the
// start pointer, wrapping from the top index back to zero.
module rr_first_valid #(
  parameter int NUM_FIFO  = 4,
  parameter int SEL_WIDTH = $clog2(NUM_FIFO)
) (
  input  logic [NUM_FIFO-1:0]  req,
  input  logic [SEL_WIDTH-1:0] start,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 found
);

  // Walk the requests in rotated order; the earliest hit wins.
  always_comb begin
    logic [SEL_WIDTH-1:0] j;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      j = SEL_WIDTH'((int'(start) + i) % NUM_FIFO);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/drr_sched.sv
// Deficit round robin scheduler. Visits queues in rotating order, tops up the
// visited queue's deficit by its quantum and grants head packets while the
// deficit covers them. A grant lasts until the packet engine reports the last
// beat of that queue's packet.
module drr_sched
  import drr_sched_pkg::*;
#(
  parameter int NUM_FIFO        = 4,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int DEFICIT_WIDTH   = DRR_DEFICIT_WIDTH,
  parameter int DEFAULT_QUANTUM = DRR_DEFAULT_QUANTUM,
  parameter int SEL_WIDTH       = $clog2(NUM_FIFO)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FIFO-1:0]               fifo_tvalid,
  input  logic [NUM_FIFO*PKT_LEN_WIDTH-1:0] fifo_packet_length,
  input  logic [NUM_FIFO-1:0]               pe_tlast,
  input  logic                              quantum_wr_en,
  input  logic [SEL_WIDTH-1:0]              quantum_wr_addr,
  input  logic [PKT_LEN_WIDTH-1:0]          quantum_wr_data,
  output logic [SEL_WIDTH-1:0]              sel_out,
  output logic                              en_out
);

  // One spare bit so the top-up carry is visible for saturation.
  localparam int SUM_W = DEFICIT_WIDTH + 1;

  drr_state_t               state, state_n;
  logic [SEL_WIDTH-1:0]     ptr, cur, pick;
  logic                     pick_found;
  logic [DEFICIT_WIDTH-1:0] deficit  [NUM_FIFO];
  logic [PKT_LEN_WIDTH-1:0] quantum  [NUM_FIFO];
  logic [PKT_LEN_WIDTH-1:0] head_len [NUM_FIFO];
  logic [PKT_LEN_WIDTH-1:0] len_r;
  logic                     deficit_ge;
  logic                     do_latch, do_add, do_clear, do_skip, do_grant, do_done;

  function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
    input logic [DEFICIT_WIDTH-1:0] a,
    input logic [PKT_LEN_WIDTH-1:0] b
  );
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return s[DEFICIT_WIDTH] ? '1 : s[DEFICIT_WIDTH-1:0];
  endfunction

  function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] i);
    return (int'(i) == NUM_FIFO - 1) ? '0 : i + 1'b1;
  endfunction

  rr_first_valid #(
    .NUM_FIFO  (NUM_FIFO),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr (
    .req   (fifo_tvalid),
    .start (ptr),
    .idx   (pick),
    .found (pick_found)
  );

  // Split the flat length bus into per-queue head lengths.
  always_comb begin
    for (int i = 0; i < NUM_FIFO; i++) begin
      head_len[i] = fifo_packet_length[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
    end
  end

  assign deficit_ge = (SUM_W'(deficit[cur]) >= SUM_W'(head_len[cur]));

  // Next-state decode and one-cycle action strobes for the datapath.
  always_comb begin
    state_n  = state;
    do_latch = 1'b0;
    do_add   = 1'b0;
    do_clear = 1'b0;
    do_skip  = 1'b0;
    do_grant = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          do_latch = 1'b1;
          state_n  = ADD;
        end
      end
      ADD: begin
        do_add  = 1'b1;
        state_n = TEST;
      end
      TEST: begin
        if (!fifo_tvalid[cur]) begin
          do_clear = 1'b1;
          state_n  = IDLE;
        end else if (deficit_ge) begin
          do_grant = 1'b1;
          state_n  = GRANT;
        end else begin
          do_skip = 1'b1;
          state_n = IDLE;
        end
      end
      GRANT: begin
        // Only the granted queue's last beat ends the grant; tvalid is ignored.
        if (pe_tlast[cur]) begin
          do_done = 1'b1;
          state_n = TEST;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Round-robin pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      sel_out <= '0;
      en_out  <= 1'b0;
    end else begin
      if (do_clear || do_skip) ptr <= next_idx(cur);
      if (do_grant)            sel_out <= cur;
      en_out <= (state_n == GRANT);
    end
  end

  // Current queue and granted length; only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (do_latch) cur   <= pick;
    if (do_grant) len_r <= head_len[cur];
  end

  // Per-queue quantum table and deficit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        deficit[i] <= '0;
        quantum[i] <= PKT_LEN_WIDTH'(DEFAULT_QUANTUM);
      end
    end else begin
      // A write landing in the ADD cycle is seen by the following visit.
      if (quantum_wr_en) quantum[quantum_wr_addr] <= quantum_wr_data;
      if (do_add)        deficit[cur] <= sat_add(deficit[cur], quantum[cur]);
      else if (do_clear) deficit[cur] <= '0;
      else if (do_done)  deficit[cur] <= deficit[cur] - DEFICIT_WIDTH'(len_r);
    end
  end

endmodule

// File: tb/tb_drr_sched.sv
// Self-checking bench for drr_sched: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// visit-by-visit behavioural model of deficit round robin.
`timescale 1ns/1ps
module tb_drr_sched;

  localparam int NF   = 4;
  localparam int PLW  = 16;
  localparam int DW   = 16;  // narrow deficit so saturation is reachable with legal lengths
  localparam int DQ   = 1500;
  localparam int SW   = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NF-1:0]     fifo_tvalid = '0;
  logic [NF*PLW-1:0] fifo_packet_length = '0;
  logic [NF-1:0]     pe_tlast;
  logic [NF-1:0]     dir_tlast = '0;
  logic [NF-1:0]     eng_tlast = '0;
  logic              auto_tl = 1'b0;
  logic              spur_on = 1'b0;
  logic              quantum_wr_en = 1'b0;
  logic [SW-1:0]     quantum_wr_addr = '0;
  logic [PLW-1:0]    quantum_wr_data = '0;
  logic [SW-1:0]     sel_out;
  logic              en_out;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  assign pe_tlast = auto_tl ? eng_tlast : dir_tlast;

  drr_sched #(
    .NUM_FIFO        (NF),
    .PKT_LEN_WIDTH   (PLW),
    .DEFICIT_WIDTH   (DW),
    .DEFAULT_QUANTUM (DQ),
    .SEL_WIDTH       (SW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_tvalid        (fifo_tvalid),
    .fifo_packet_length (fifo_packet_length),
    .pe_tlast           (pe_tlast),
    .quantum_wr_en      (quantum_wr_en),
    .quantum_wr_addr    (quantum_wr_addr),
    .quantum_wr_data    (quantum_wr_data),
    .sel_out            (sel_out),
    .en_out             (en_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_len(input int q, input int v);
    fifo_packet_length[q*PLW +: PLW] = PLW'(v);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    fifo_tvalid   = '0;
    dir_tlast     = '0;
    auto_tl       = 1'b0;
    spur_on       = 1'b0;
    quantum_wr_en = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic write_quantum(input int q, input int v);
    quantum_wr_en   = 1'b1;
    quantum_wr_addr = SW'(q);
    quantum_wr_data = PLW'(v);
    step();
    quantum_wr_en = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  int m_def  [NF];
  int m_q    [NF];
  int m_qold [NF];
  int m_ptr;
  int m_sel;
  bit m_en;
  bit [NF-1:0] s_tv, s_tl;
  int s_len [NF];

  function automatic int first_valid(input logic [NF-1:0] v, input int p);
    for (int k = 0; k < NF; k++) if (v[(p + k) % NF]) return (p + k) % NF;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_def[i] = 0;
      m_q[i]   = DQ;
    end
    m_ptr = 0;
    m_sel = 0;
    m_en  = 1'b0;
  endtask

  // One clock edge: sample inputs, handle reset, apply any quantum write
  // (the quantum in force before this edge stays visible as m_qold).
  task automatic m_edge(output bit r);
    @(posedge clk);
    s_tv = fifo_tvalid;
    s_tl = pe_tlast;
    for (int i = 0; i < NF; i++) s_len[i] = int'(fifo_packet_length[i*PLW +: PLW]);
    m_qold = m_q;
    if (rst) begin
      model_reset();
      r = 1'b1;
    end else begin
      r = 1'b0;
      if (quantum_wr_en) m_q[quantum_wr_addr] = int'(quantum_wr_data);
    end
  endtask

  // A visit: pick a queue, top up, then serve packets while the deficit lasts.
  initial begin : model
    bit r;
    int c, l;
    model_reset();
    forever begin
      m_edge(r);
      if (r || s_tv == '0) continue;
      c = first_valid(s_tv, m_ptr);
      m_edge(r);
      if (r) continue;
      m_def[c] = (m_def[c] + m_qold[c] > DMAX) ? DMAX : m_def[c] + m_qold[c];
      forever begin
        m_edge(r);
        if (r) break;
        if (!s_tv[c]) begin
          m_def[c] = 0;
          m_ptr    = (c + 1) % NF;
          break;
        end
        if (m_def[c] < s_len[c]) begin
          m_ptr = (c + 1) % NF;
          break;
        end
        l     = s_len[c];
        m_en  = 1'b1;
        m_sel = c;
        do m_edge(r); while (!r && !s_tl[c]);
        if (r) break;
        m_def[c] = m_def[c] - l;
        m_en     = 1'b0;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("en_out", int'(en_out), int'(m_en));
      check("sel_out", int'(sel_out), m_sel);
      check("ptr", int'(dut.ptr), m_ptr);
      for (int i = 0; i < NF; i++)
        check($sformatf("deficit%0d", i), int'(dut.deficit[i]), m_def[i]);
    end
  end

  // Packet engine: ends grants after a random time, plus stray pulses.
  always @(negedge clk) begin
    eng_tlast = '0;
    if (en_out && $urandom_range(0, 2) == 0) eng_tlast[sel_out] = 1'b1;
    if (spur_on && $urandom_range(0, 7) == 0) eng_tlast[$urandom_range(0, NF-1)] = 1'b1;
  end

  // Log of granted queues, one entry per rising en_out.
  int glog[$];
  bit en_prev = 1'b0;
  always @(negedge clk) begin
    if (en_out && !en_prev) glog.push_back(int'(sel_out));
    en_prev = en_out;
  end

  task automatic wait_grants(input string name, input int n);
    int k = 0;
    while (glog.size() < n && k < 400) begin
      step();
      k++;
    end
    if (glog.size() < n) check({name, "_timeout"}, glog.size(), n);
  endtask

  function automatic int rand_len();
    int r = $urandom_range(0, 19);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(1800, 3000);
    return $urandom_range(1, 1600);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int exp_b[5];
    int exp_c[8];
    int k;
    exp_b = '{0, 1, 2, 3, 0};
    exp_c = '{0, 1, 1, 2, 3, 0, 1, 1};

    do_reset();
    chk_on = 1'b1;
    check("rst_en", int'(en_out), 0);
    check("rst_sel", int'(sel_out), 0);

    // Single queue 0, length 1000: latency, deficit carry, second visit.
    set_len(0, 1000);
    fifo_tvalid = 4'b0001;
    step(); check("A_lat1", int'(en_out), 0);
    step(); check("A_lat2", int'(en_out), 0);
    step(); check("A_lat3", int'(en_out), 1);
    check("A_sel", int'(sel_out), 0);
    check("A_def_add", int'(dut.deficit[0]), 1500);
    dir_tlast = 4'b0001;
    step(); dir_tlast = '0;
    check("A_def_sub", int'(dut.deficit[0]), 500);
    check("A_model_def", m_def[0], 500);
    check("A_en_drop", int'(en_out), 0);
    step(); check("A_ptr", int'(dut.ptr), 1);
    repeat (3) step();
    check("A_regrant", int'(en_out), 1);
    check("A_def2000", int'(dut.deficit[0]), 2000);
    fifo_tvalid = '0;
    step(); check("A_hold_no_tvalid", int'(en_out), 1);
    dir_tlast = 4'b0001;
    step(); dir_tlast = '0;
    check("A_def1000", int'(dut.deficit[0]), 1000);
    step(); check("A_def_clear", int'(dut.deficit[0]), 0);

    // All four queues, length = quantum = 1500.
    do_reset();
    glog.delete();
    for (int i = 0; i < NF; i++) set_len(i, 1500);
    auto_tl     = 1'b1;
    fifo_tvalid = '1;
    wait_grants("B", 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("B_order%0d", i), (i < glog.size()) ? glog[i] : -1, exp_b[i]);
    fifo_tvalid = '0;
    repeat (20) step();

    // Queue 1 with double quantum gets two grants per round.
    do_reset();
    write_quantum(1, 3000);
    glog.delete();
    for (int i = 0; i < NF; i++) set_len(i, 1500);
    auto_tl     = 1'b1;
    fifo_tvalid = '1;
    wait_grants("C", 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("C_order%0d", i), (i < glog.size()) ? glog[i] : -1, exp_c[i]);
    fifo_tvalid = '0;
    repeat (20) step();

    // Queue 2 empties while holding deficit 700.
    do_reset();
    set_len(2, 800);
    fifo_tvalid = 4'b0100;
    repeat (3) step();
    check("D_grant", int'(en_out), 1);
    check("D_sel", int'(sel_out), 2);
    dir_tlast   = 4'b0100;
    fifo_tvalid = '0;
    step(); dir_tlast = '0;
    check("D_def700", int'(dut.deficit[2]), 700);
    check("D_model700", m_def[2], 700);
    step();
    check("D_def_clear", int'(dut.deficit[2]), 0);
    check("D_ptr3", int'(dut.ptr), 3);

    // Stray pe_tlast during a grant, then reset mid-grant.
    do_reset();
    set_len(1, 100);
    fifo_tvalid = 4'b0010;
    repeat (3) step();
    check("E_grant", int'(en_out), 1);
    dir_tlast = 4'b1000;
    step(); dir_tlast = '0;
    check("E_stray_en", int'(en_out), 1);
    check("E_stray_sel", int'(sel_out), 1);
    check("E_stray_def", int'(dut.deficit[1]), 1500);
    rst       = 1'b1;
    dir_tlast = 4'b0010;
    step();
    rst = 1'b0; dir_tlast = '0; fifo_tvalid = '0;
    check("E_rst_en", int'(en_out), 0);
    check("E_rst_def", int'(dut.deficit[1]), 0);

    // Small quantum: three visits before the first grant.
    do_reset();
    write_quantum(0, 100);
    set_len(0, 300);
    fifo_tvalid = 4'b0001;
    k = 0;
    while (!en_out && k < 60) begin step(); k++; end
    check("F_cycles", k, 9);
    check("F_def300", int'(dut.deficit[0]), 300);
    dir_tlast = 4'b0001; fifo_tvalid = '0;
    step(); dir_tlast = '0;
    step();

    // Saturation of the deficit, then a zero-length packet.
    do_reset();
    write_quantum(0, 40000);
    set_len(0, 65535);
    fifo_tvalid = 4'b0001;
    k = 0;
    while (!en_out && k < 60) begin step(); k++; end
    check("G_cycles", k, 6);
    check("G_sat", int'(dut.deficit[0]), 65535);
    check("G_model_sat", m_def[0], 65535);
    dir_tlast = 4'b0001;
    set_len(0, 0);
    step(); dir_tlast = '0;
    check("G_def0", int'(dut.deficit[0]), 0);
    check("G_gap", int'(en_out), 0);
    step();
    check("G_zero_grant", int'(en_out), 1);
    dir_tlast = 4'b0001;
    step(); dir_tlast = '0;
    check("G_zero_def", int'(dut.deficit[0]), 0);
    fifo_tvalid = '0;
    repeat (4) step();

    // Randomized traffic, quantum writes, stray last beats and resets.
    do_reset();
    auto_tl = 1'b1;
    spur_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) fifo_tvalid = NF'($urandom());
      if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, NF-1), rand_len());
      quantum_wr_en   = ($urandom_range(0, 15) == 0);
      quantum_wr_addr = SW'($urandom_range(0, NF-1));
      quantum_wr_data = PLW'($urandom_range(0, 2500));
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst           = 1'b0;
    quantum_wr_en = 1'b0;
    fifo_tvalid   = '0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drr_sched.md
DRR_SCHED -- requirements
Module: drr_sched

Interface
REQ-001 SHALL have parameter NUM_FIFO, default 4, number of queues served.
REQ-002 SHALL have parameter PKT_LEN_WIDTH, default 16, packet length width in bytes.
REQ-003 SHALL have parameter DEFICIT_WIDTH, default 20, per-queue deficit counter width.
REQ-004 SHALL have parameter DEFAULT_QUANTUM, default 1500, quantum reset value for every queue.
REQ-005 SHALL have parameter SEL_WIDTH, default $clog2(NUM_FIFO), queue index width.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 fifo_tvalid  input  NUM_FIFO  queue i holds at least one packet.
REQ-009 fifo_packet_length  input  NUM_FIFO*PKT_LEN_WIDTH  head-packet length; queue i occupies bits [i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH].
REQ-010 pe_tlast  input  NUM_FIFO  one-cycle pulse: the last beat of queue i's packet was accepted.
REQ-011 quantum_wr_en  input  1  quantum write strobe.
REQ-012 quantum_wr_addr  input  SEL_WIDTH  queue index to write.
REQ-013 quantum_wr_data  input  PKT_LEN_WIDTH  new quantum in bytes.
REQ-014 sel_out  output  SEL_WIDTH  granted queue index; registered.
REQ-015 en_out  output  1  grant valid; registered.

Function
REQ-016 SHALL implement FSM states IDLE, ADD, TEST, GRANT.
REQ-017 IDLE: if any fifo_tvalid is high, SHALL latch cur = first valid index at or after rr pointer ptr (rotating priority, wrapping NUM_FIFO-1 to 0) and go to ADD; otherwise SHALL stay in IDLE.
REQ-018 ADD: SHALL set deficit[cur] = deficit[cur] + quantum[cur], saturating at 2^DEFICIT_WIDTH-1, then go to TEST.
REQ-019 TEST, fifo_tvalid[cur] low: SHALL clear deficit[cur] to 0, set ptr = cur+1 mod NUM_FIFO, and go to IDLE.
REQ-020 TEST, deficit[cur] >= head length: SHALL latch the length into len_r, drive sel_out = cur and en_out = 1 on the next cycle, and go to GRANT.
REQ-021 TEST, deficit[cur] < head length: SHALL keep deficit[cur], set ptr = cur+1 mod NUM_FIFO, and go to IDLE.
REQ-022 GRANT: SHALL hold sel_out and en_out until pe_tlast[cur]; then SHALL set deficit[cur] = deficit[cur] - len_r, drop en_out on the next cycle, and go to TEST without adding quantum.
REQ-023 pe_tlast on a non-granted queue, or outside GRANT, SHALL be ignored.
REQ-024 Deassertion of fifo_tvalid[cur] during GRANT SHALL NOT end the grant; only pe_tlast ends it.
REQ-025 Latency: with the FSM in IDLE and deficit sufficient, en_out SHALL rise exactly 3 cycles after fifo_tvalid is first sampled high.
REQ-026 A quantum write SHALL take effect at the next ADD; a write coinciding with ADD for the same queue SHALL use the old value.
REQ-027 Deficit arithmetic SHALL be unsigned; the subtraction cannot underflow because a grant requires deficit >= len_r.
REQ-028 Zero-length packets SHALL be granted without a deficit change.

Reset
REQ-029 On rst: state = IDLE, ptr = 0, en_out = 0, sel_out = 0, all deficits = 0, all quanta = DEFAULT_QUANTUM.
REQ-030 rst asserted during GRANT SHALL drop en_out on the following cycle; in-flight pe_tlast SHALL be discarded.

Structure
REQ-031 Package drr_sched_pkg SHALL hold the FSM state encoding and the DEFAULT_QUANTUM and DEFICIT_WIDTH constants.
REQ-032 The rotating first-valid search SHALL be a sub-module rr_first_valid (inputs: request vector, start pointer; outputs: index, found).

Verification
REQ-033 Single queue 0, quantum 1500, length 1000, tvalid held: en_out rises 3 cycles after tvalid; after pe_tlast deficit = 500 and queue 0 is re-tested; 500 < 1000 moves ptr to 1, next visit gives deficit 2000 and a grant.
REQ-034 Queues 0-3 all valid, length 1500, quantum 1500: grants in order 0,1,2,3,0, one packet each.
REQ-035 Quantum 3000 on queue 1, 1500 elsewhere, length 1500, all valid: two queue-1 grants per round, one for each other queue.
REQ-036 Queue 2 empties in TEST with deficit 700: deficit[2] cleared to 0, ptr = 3.
REQ-037 pe_tlast[3] pulsed while queue 1 is granted: no state change; rst mid-GRANT: en_out = 0 next cycle, all deficits 0.
REQ-038 Quantum write of 100 to queue 0 with length 300: three visits before the first grant.
